// File: rtl/uart_tx_scheduler_if.sv
// Producer-side bundle for uart_tx_scheduler: request/data/grant handshake,
// bit-period strobe and the serial line with its status.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic                      baud_tick;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic [ID_W-1:0]           active_id;
    logic                      tx;

    modport master (
        output baud_tick, req, data,
        input  gnt, busy, active_id, tx
    );

    modport slave (
        input  baud_tick, req, data,
        output gnt, busy, active_id, tx
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of a single UART transmitter: grants one
// requester per frame and serialises start, LSB-first data and stop bits.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int BW = $clog2(DATA_W);
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic [SW-1:0]      stopcnt_q, stopcnt_d;

    logic               found;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W:0]      cand;

    // First requester at or after rr_ptr, wrapping at NUM_REQ (not 2**ID_W).
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && bus.req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                sel_id = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        gnt_d       = '0;
        active_id_d = active_id_q;
        rr_ptr_d    = rr_ptr_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (found) begin
                    gnt_d       = NUM_REQ'(1) << sel_id;
                    shreg_d     = bus.data[sel_id*DATA_W +: DATA_W];
                    active_id_d = sel_id;
                    rr_ptr_d    = (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + ID_W'(1);
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (bus.baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bus.baud_tick) begin
                    if (bitcnt_q == BW'(DATA_W-1)) begin
                        tx_d      = 1'b1;
                        stopcnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.baud_tick) begin
                    if (stopcnt_q == SW'(STOP_BITS-1)) begin
                        state_d = IDLE;
                    end else begin
                        stopcnt_d = stopcnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            gnt_q       <= '0;
            active_id_q <= '0;
            rr_ptr_q    <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            stopcnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
            active_id_q <= active_id_d;
            rr_ptr_q    <= rr_ptr_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            stopcnt_q   <= stopcnt_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.gnt       = gnt_q;
    assign bus.active_id = active_id_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of frame requests plus
// hand sequences for mid-frame reset, tick/grant collision and 2 stop bits.
module tb_uart_tx_scheduler;
    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int BAUD = 16;
    localparam int NV   = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(2)) bus ();
    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(2)) bus2 ();

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(1), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(2), .ID_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Baud strobe: one clk high every BAUD clks, phase set by tick_base.
    int cyc = 0;
    int tick_base = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        bus.baud_tick  = ((cyc - tick_base) % BAUD == 0);
        bus2.baud_tick = ((cyc - tick_base) % BAUD == 0);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int last_end = 0;

    typedef struct {
        logic           do_rst;
        logic [NR-1:0]  req;
        logic           load;
        logic [NR*DW-1:0] data;
        logic           hold;
        int             exp_sel;
        logic           chk_gap;
    } vec_t;
    vec_t vecs[NV];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [NR-1:0] mask, input logic hold,
                             input int exp_sel, input logic chk_gap);
        logic [DW-1:0] byte_exp;
        logic          bit_exp;
        int            waited;
        int            bad;
        bus.req = mask;
        waited = 0;
        do begin
            step();
            waited++;
        end while (bus.gnt == '0 && waited < 400);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << exp_sel);
        if (bus.gnt == '0) return;
        byte_exp = bus.data[exp_sel*DW +: DW];
        if (hold) bus.data[exp_sel*DW +: DW] = ~byte_exp;
        else      bus.req = '0;
        step();
        check({tag, "_gnt_pulse"}, 32'(bus.gnt), 0);
        check({tag, "_active_id"}, 32'(bus.active_id), 32'(exp_sel));
        check({tag, "_busy"}, 32'(bus.busy), 1);
        waited = 0;
        while (bus.tx !== 1'b0 && waited < 40) begin
            step();
            waited++;
        end
        check({tag, "_start"}, 32'(bus.tx), 0);
        if (bus.tx !== 1'b0) return;
        if (chk_gap) check({tag, "_gap_ok"}, 32'(((cyc - last_end) >= BAUD) && ((cyc - last_end) < 2*BAUD)), 1);
        for (int b = 0; b < DW + 2; b++) begin
            bit_exp = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : byte_exp[b-1];
            bad = 0;
            for (int c = 0; c < BAUD; c++) begin
                if (bus.tx !== bit_exp || bus.busy !== 1'b1) bad++;
                step();
            end
            check($sformatf("%s_bit%0d_badcycles", tag, b), 32'(bad), 0);
        end
        check({tag, "_busy_drop"}, 32'(bus.busy), 0);
        check({tag, "_tx_idle"}, 32'(bus.tx), 1);
        last_end = cyc;
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        bus.req = '0;
        bus.data = '0;
        bus2.req = '0;
        bus2.data = '0;
        step();
        step();
        step();
        check("rst_tx", 32'(bus.tx), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_active_id", 32'(bus.active_id), 0);
        check("rst_tx2", 32'(bus2.tx), 1);
        rst = 1'b0;

        vecs[0]  = '{1'b1, 4'b0001, 1'b1, 32'h0000_00A5, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 1'b1, 32'h4433_2211, 1'b1, 0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         1'b1, 1, 1'b1};
        vecs[3]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         1'b1, 2, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         1'b1, 3, 1'b1};
        vecs[5]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         1'b0, 0, 1'b1};
        vecs[6]  = '{1'b0, 4'b0100, 1'b1, 32'h01FF_0080, 1'b0, 2, 1'b1};
        vecs[7]  = '{1'b0, 4'b0011, 1'b0, 32'h0,         1'b0, 0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0010, 1'b0, 32'h0,         1'b0, 1, 1'b1};
        vecs[9]  = '{1'b0, 4'b1000, 1'b0, 32'h0,         1'b0, 3, 1'b1};
        vecs[10] = '{1'b0, 4'b1001, 1'b0, 32'h0,         1'b0, 0, 1'b1};
        vecs[11] = '{1'b0, 4'b0101, 1'b0, 32'h0,         1'b0, 2, 1'b1};
        vecs[12] = '{1'b0, 4'b0110, 1'b0, 32'h0,         1'b0, 1, 1'b1};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_rst) reset_dut();
            if (vecs[i].load) bus.data = vecs[i].data;
            run_frame($sformatf("v%0d", i), vecs[i].req, vecs[i].hold, vecs[i].exp_sel, vecs[i].chk_gap);
        end

        // Reset in the middle of data bit 4 of a frame from requester 1.
        reset_dut();
        bus.data[1*DW +: DW] = 8'h3C;
        bus.req = 4'b0010;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == '0 && n < 400);
        check("abort_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        n = 0;
        while (bus.tx !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check("abort_start", 32'(bus.tx), 0);
        repeat (5*BAUD + BAUD/2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_tx", 32'(bus.tx), 1);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_gnt_low", 32'(bus.gnt), 0);
        check("abort_active_id", 32'(bus.active_id), 0);
        bad = 0;
        repeat (20) begin
            step();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        check("abort_quiet_badcycles", 32'(bad), 0);
        run_frame("post_rst_ptr", 4'b0110, 1'b0, 1, 1'b0);
        bus.data[2*DW +: DW] = 8'h96;
        run_frame("post_rst_frame", 4'b0100, 1'b0, 2, 1'b1);

        // Grant edge coincides with a baud tick: start must wait a full period.
        tick_base = cyc + 1;
        step();
        bus.data[3*DW +: DW] = 8'h5A;
        bus.req = 4'b1000;
        step();
        check("align_gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        n = 0;
        while (bus.tx !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check("align_start_delay", 32'(n), BAUD);
        n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        check("align_busy_drop", 32'(bus.busy), 0);

        // Two stop bits: stop level held for 2*BAUD clks, then busy drops.
        bus2.data[0 +: DW] = 8'hC3;
        bus2.req = 4'b0001;
        n = 0;
        do begin
            step();
            n++;
        end while (bus2.gnt == '0 && n < 400);
        check("stop2_gnt", 32'(bus2.gnt), 32'h1);
        bus2.req = '0;
        n = 0;
        while (bus2.tx !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check("stop2_start", 32'(bus2.tx), 0);
        repeat ((DW + 1)*BAUD) step();
        bad = 0;
        repeat (2*BAUD) begin
            if (bus2.tx !== 1'b1 || bus2.busy !== 1'b1) bad++;
            step();
        end
        check("stop2_hold_badcycles", 32'(bad), 0);
        check("stop2_busy_drop", 32'(bus2.busy), 0);
        check("stop2_tx_idle", 32'(bus2.tx), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit line between NUM_REQ byte producers using round-robin arbitration.
- Sequences each frame as start bit, DATA_W data bits LSB first, then STOP_BITS stop bits.
- All bit timing comes from baud_tick, a one-clk pulse per bit period produced by the baud generator in the same clk domain.
- Sits between the baud generator and the board TX pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1..2).
- ID_W, $clog2(NUM_REQ), width of active_id.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle bit-period strobe; ignored in IDLE.
- req  input  NUM_REQ  per-requester send request, held high until its gnt.
- data  input  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i] is high.
- gnt  output  NUM_REQ  one-hot, one-cycle acceptance pulse; data latched on this edge.
- busy  output  1  high whenever state is not IDLE.
- active_id  output  ID_W  index of the last granted requester.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset is clk, rst, synchronous, active-high. It has priority over everything, including mid-frame. It forces:
  - state=IDLE, tx=1, gnt=0, busy=0, active_id=0, rr_ptr=0.
  - Any frame in progress is aborted; tx reads 1 from the next cycle.
- All outputs are registered.
- States are IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - If req is nonzero, select the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - On that edge: gnt=onehot(sel), shreg=data slice of sel, active_id=sel, rr_ptr=(sel+1) mod NUM_REQ, state=LOAD.
  - The gnt pulse lasts one cycle. req seen during the gnt cycle is not re-arbitrated. Requesters deassert req or present new data by the cycle after gnt.
  - A requester may withdraw req before grant with no effect.
  - baud_tick in IDLE is ignored, including a tick in the same cycle as a grant.
- LOAD: on baud_tick, tx=0, state=START. Without a tick, hold with tx=1.
- START: on baud_tick, tx=shreg[0], shreg shifted right, bitcnt=0, state=DATA.
- DATA: on each baud_tick:
  - If bitcnt==DATA_W-1: tx=1, stopcnt=0, state=STOP.
  - Else: tx=shreg[0], shift, bitcnt+1.
- STOP: on baud_tick:
  - If stopcnt==STOP_BITS-1: state=IDLE, tx stays 1.
  - Else: stopcnt+1.
- Bit timing:
  - Every line level (start, each data bit, each stop bit) lasts exactly one baud_tick interval, measured tick to tick.
  - Changes on tx occur only on clock edges where baud_tick=1, apart from reset.
- Inter-frame gap:
  - After the final stop tick, arbitration takes one clk in IDLE, then LOAD waits for the next tick.
  - The idle-high gap between the end of the stop bit and the next start bit is therefore at least one bit period and under two.
- Fairness: with all req held high, grants cycle 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 frames.
- busy is high from the cycle after grant until the cycle after the final stop tick.
- Counters bitcnt and stopcnt use $clog2-based widths and never wrap beyond their terminal values.

Test Plan:
1. Setup for all scenarios: NUM_REQ=4, DATA_W=8, STOP_BITS=1, baud_tick every 16 clk.
2. Single request: req=0001, data0=8'hA5 -> gnt=0001 for 1 cycle. tx sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop). Each level lasts 16 clk. busy then drops and active_id=0.
3. Round-robin: req=1111 held with new data after each gnt -> grant order 0,1,2,3,0. Each frame is separated by at least one idle bit period of tx=1.
4. Pointer wrap: after a grant to 2, assert req=0011 -> grant to 0, then 1. Asserting req=1001 after a grant to 3 -> grant to 0.
5. Reset mid-frame: assert rst during DATA bit 4 for 1 cycle -> next cycle tx=1, busy=0, gnt=0, rr_ptr=0. A subsequent req=0100 is granted and sends a clean full frame.
6. Tick alignment: baud_tick coincides with the grant cycle -> that tick is ignored, and the start bit begins on the following tick. Also check STOP_BITS=2 -> stop level holds for 32 clk.
